axis_stream_checker: RTL
========================

Name: axis_stream_checker

Overview:
- AXI-Stream slave that terminates the memory read-out stream and checks it against the known generator pattern.
- Sits on the far end of the generator → memory chain as the receiving sink; accepts beats, compares data, strobe and frame length, and keeps status counters.
- Used in lab builds and as a self-checking sink in system benches.

Parameters:
- DATA_WIDTH, 32, tdata width in bits; must be a multiple of 8.
- FRAME_LEN, 8, beats per frame; tlast is expected on beat FRAME_LEN-1; minimum 2.
- SEED, 0, expected tdata of beat 0 of every frame.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- s04_axis_aclk  input  1  clock.
- s04_axis_aresetn  input  1  synchronous active-low reset.
- enable  input  1  start/continue checking.
- clear  input  1  synchronous clear of counters and sticky flags.
- s04_axis_tdata  input  DATA_WIDTH  stream data.
- s04_axis_tstrb  input  DATA_WIDTH/8  byte strobes.
- s04_axis_tvalid  input  1  beat valid.
- s04_axis_tlast  input  1  last beat of frame.
- s04_axis_tready  output  1  ready to accept.
- frame_count  output  CNT_WIDTH  frames closed (tlast accepted).
- error_count  output  CNT_WIDTH  error events.
- data_error  output  1  sticky; tdata or tstrb mismatch seen.
- len_error  output  1  sticky; frame length violation seen.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Interface: one clock (s04_axis_aclk); reset is synchronous and active-low (s04_axis_aresetn), sampled on the rising edge.
- Reset: FSM=IDLE; tready=0; beat index=0; all counters=0; data_error=0; len_error=0; busy=0.
- Accept: a beat is accepted on a rising edge with tvalid && tready. Nothing is sampled otherwise.
- tready: driven from the state register (plus LFSR when the option is enabled). It is 1 in RECV and FLUSH, 0 in IDLE. Upstream must hold the beat stable while tvalid=1 and tready=0.
- Expected data: exp = SEED + idx, truncated to DATA_WIDTH bits, so it wraps modulo 2^DATA_WIDTH. idx is the beat index within the frame, 0..FRAME_LEN-1, and resets to 0 at every frame close.
- FSM states are IDLE, RECV and FLUSH.
- IDLE → RECV when enable=1. tready rises the next cycle.
- RECV, per accepted beat:
  - tdata != exp, or tstrb != all-ones: set data_error; error_count+1 (one increment per beat, even if both mismatch).
  - tlast=1 with idx < FRAME_LEN-1 (early tlast): set len_error; error_count+1; close the frame.
  - tlast=1 with idx == FRAME_LEN-1: close the frame normally.
  - tlast=0 with idx == FRAME_LEN-1 (missing tlast): set len_error; error_count+1; go to FLUSH.
  - Otherwise: idx+1.
  - One beat may add 2 to error_count: a data error plus a length error.
- FLUSH: accepts beats without data comparison until tlast is accepted, then closes the frame. Extra beats add no further errors.
- Frame close: frame_count+1; idx=0. Go to RECV if enable=1, else IDLE.
- enable deasserted mid-frame: the current frame completes (RECV/FLUSH continue until tlast). Then IDLE.
- Counters saturate at all-ones; no wrap.
- clear=1: in the same cycle, zero both counters and both sticky flags. It has priority over events in that cycle, which are dropped. FSM and idx are unaffected.
- Reset mid-frame: returns to IDLE immediately. The partial frame is discarded and not counted.
- busy = (state != IDLE).

Optional Feature:
- Macro: AXIS_CHECKER_BACKPRESSURE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to 16'hACE1, advances every cycle.
  - tready = (state != IDLE) && lfsr[0]. Gives pseudo-random backpressure.
- Undefined: no LFSR; tready = (state != IDLE).
- Checking results must be identical in both builds for the same accepted beat sequence.

Test Plan (DATA_WIDTH=32, FRAME_LEN=8, SEED=0):
- Clean frames: enable=1; send 3 frames of 0..7 with tlast on beat 7 and tstrb=4'hF → frame_count=3, error_count=0, both flags 0, busy=1.
- Data error: frame with beat 3 = 32'hDEAD_BEEF → data_error=1, error_count=1, frame_count=1. The next clean frame adds no errors.
- Early tlast: tlast on beat 4 → len_error=1, error_count=1, frame_count=1. The following frame expects tdata=0 again.
- Missing tlast: 10 beats, tlast on beat 9 → len_error=1, error_count=1, FLUSH during beats 8..9, frame_count=1. A clean frame follows without error.
- Stall/enable: tvalid toggled every other cycle, enable dropped after beat 2 → frame still completes at tlast, then tready=0, busy=0, frame_count=1.
- Clear and reset: error_count=5; pulse clear together with a mismatching beat → counters and flags read 0 the next cycle. Assert reset mid-frame → all outputs return to reset values within one edge.

Source files
------------

// File: rtl/axis_stream_checker.sv
// AXI-Stream sink that checks the generator pattern (SEED + beat index), frame length and strobes.
// Optional macro AXIS_CHECKER_BACKPRESSURE_EN adds LFSR-driven pseudo-random backpressure on tready.
module axis_stream_checker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAME_LEN  = 8,
  parameter int unsigned SEED       = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    s04_axis_aclk,
  input  logic                    s04_axis_aresetn,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   s04_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s04_axis_tstrb,
  input  logic                    s04_axis_tvalid,
  input  logic                    s04_axis_tlast,
  output logic                    s04_axis_tready,
  output logic [CNT_WIDTH-1:0]    frame_count,
  output logic [CNT_WIDTH-1:0]    error_count,
  output logic                    data_error,
  output logic                    len_error,
  output logic                    busy
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH  = $clog2(FRAME_LEN);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IDX_WIDTH-1:0]   idx;
  logic [IDX_WIDTH-1:0]   idx_nxt;
  logic [DATA_WIDTH-1:0]  exp_data;
  logic                   accept;
  logic                   data_bad;
  logic                   len_bad;
  logic                   frame_close;
  logic [1:0]             err_inc;
  logic                   ready_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [1:0]           inc);
    logic [CNT_WIDTH:0] sum;
    sum = (CNT_WIDTH+1)'(cnt) + (CNT_WIDTH+1)'(inc);
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  // Per-beat decode: compare against the expected pattern and track frame position.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    data_bad    = 1'b0;
    len_bad     = 1'b0;
    frame_close = 1'b0;
    accept      = s04_axis_tvalid && s04_axis_tready;
    exp_data    = DATA_WIDTH'(SEED) + DATA_WIDTH'(idx);
    case (state)
      IDLE: begin
        if (enable) state_nxt = RECV;
      end
      RECV: begin
        if (accept) begin
          data_bad = (s04_axis_tdata != exp_data) || (s04_axis_tstrb != {STRB_WIDTH{1'b1}});
          if (s04_axis_tlast) begin
            frame_close = 1'b1;
            len_bad     = (idx != LAST_IDX);
          end else if (idx == LAST_IDX) begin
            len_bad   = 1'b1;
            state_nxt = FLUSH;
          end else begin
            idx_nxt = idx + IDX_WIDTH'(1);
          end
        end
      end
      FLUSH: begin
        if (accept && s04_axis_tlast) frame_close = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (frame_close) begin
      idx_nxt   = '0;
      state_nxt = enable ? RECV : IDLE;
    end
    err_inc = {1'b0, data_bad} + {1'b0, len_bad};
  end

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign ready_nxt = (state_nxt != IDLE) && lfsr_nxt[0];

  always_ff @(posedge s04_axis_aclk) begin
    if (!s04_axis_aresetn) lfsr <= 16'hACE1;
    else                   lfsr <= lfsr_nxt;
  end
`else
  assign ready_nxt = (state_nxt != IDLE);
`endif

  // State, index, status counters and sticky flags; clear wins over same-cycle events.
  always_ff @(posedge s04_axis_aclk) begin
    if (!s04_axis_aresetn) begin
      state           <= IDLE;
      idx             <= '0;
      s04_axis_tready <= 1'b0;
      busy            <= 1'b0;
      frame_count     <= '0;
      error_count     <= '0;
      data_error      <= 1'b0;
      len_error       <= 1'b0;
    end else begin
      state           <= state_nxt;
      idx             <= idx_nxt;
      s04_axis_tready <= ready_nxt;
      busy            <= (state_nxt != IDLE);
      if (clear) begin
        frame_count <= '0;
        error_count <= '0;
        data_error  <= 1'b0;
        len_error   <= 1'b0;
      end else begin
        if (frame_close)    frame_count <= sat_add(frame_count, 2'd1);
        if (err_inc != 2'd0) error_count <= sat_add(error_count, err_inc);
        if (data_bad)       data_error  <= 1'b1;
        if (len_bad)        len_error   <= 1'b1;
      end
    end
  end

endmodule
